// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared definitions for the stage-E multiply/divide unit.
//   hilo_op_e  : HI/LO-class operation encoding driven by decode
//   mdu_state_e: sequencer state encoding
//   *_CYCLES_DEF: default busy latencies (cycles after issue)
package e_mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } hilo_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/e_mdu_arith.sv
// e_mdu_arith: combinational 32x32 multiply / divide datapath.
//   op       : operation (only MULT/MULTU/DIV/DIVU produce a result)
//   rs, rt   : operands (rs = multiplicand / dividend)
//   res_hi   : product upper half, or remainder
//   res_lo   : product lower half, or quotient
//   div_zero : div/divu with rt == 0 (result must not be committed)
module e_mdu_arith
  import e_mdu_pkg::*;
(
  input  hilo_op_e    op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic        is_signed, neg_a, neg_b, neg_q;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
  logic [63:0] p_mag, prod;

  // Signed ops are done on magnitudes and the sign fixed afterwards; this
  // keeps MIN_INT / -1 well defined (quotient wraps to 0x80000000, rem 0).
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    neg_a     = is_signed & rs[31];
    neg_b     = is_signed & rt[31];
    neg_q     = neg_a ^ neg_b;
    a_mag     = neg_a ? (~rs + 32'd1) : rs;
    b_mag     = neg_b ? (~rt + 32'd1) : rt;
    b_safe    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    p_mag     = {32'd0, a_mag} * {32'd0, b_mag};
    prod      = neg_q ? (~p_mag + 64'd1) : p_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    div_zero  = 1'b0;
    res_hi    = 32'd0;
    res_lo    = 32'd0;
    case (op)
      OP_MULT, OP_MULTU: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      OP_DIV, OP_DIVU: begin
        div_zero = (rt == 32'd0);
        res_lo   = neg_q ? (~q_mag + 32'd1) : q_mag;
        res_hi   = neg_a ? (~r_mag + 32'd1) : r_mag;   // sign of dividend
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: multi-cycle mult/div sequencer for stage E; owns HI/LO.
//   clk, reset : clock, asynchronous active-high reset
//   hilo_type  : HI/LO-class op of the instruction in E (e_mdu_pkg encoding)
//   rs, rt     : forwarded operands
//   flush      : abort in-flight op (honoured only with MDU_FLUSH_EN defined)
//   busy       : start request this cycle OR operation in progress
//   hilo_out   : HI for MFHI, LO for MFLO, else 0
//   hi, lo     : architectural registers
//   done       : one-cycle pulse in the cycle a result is committed
// Optional feature macro: MDU_FLUSH_EN
module e_mdu_ctrl
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  hilo_type,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hilo_out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  hilo_op_e    op;
  mdu_state_e  state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi, pend_lo, res_hi, res_lo;
  logic        pend_zero, div_zero, start, is_div, flush_act;

  assign op     = hilo_op_e'(hilo_type);
  assign start  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  // Combinational so the stall unit sees busy in the issue cycle.
  assign busy   = start | (state == ST_BUSY);

`ifdef MDU_FLUSH_EN
  assign flush_act = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  always_comb begin
    hilo_out = 32'd0;
    if (op == OP_MFHI)      hilo_out = hi;
    else if (op == OP_MFLO) hilo_out = lo;
  end

  e_mdu_arith u_arith (
    .op       (op),
    .rs       (rs),
    .rt       (rt),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      done      <= 1'b0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A flush in IDLE kills whatever op sits in E this cycle.
          if (!flush_act) begin
            if (start) begin
              pend_hi   <= res_hi;
              pend_lo   <= res_lo;
              pend_zero <= div_zero;
              cnt       <= is_div ? DIV_CNT : MULT_CNT;
              state     <= ST_BUSY;
            end else if (op == OP_MTHI) begin
              hi <= rs;
            end else if (op == OP_MTLO) begin
              lo <= rs;
            end
          end
        end
        ST_BUSY: begin
          // New starts and MTHI/MTLO are ignored while busy.
          if (flush_act) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd1) begin
            if (!pend_zero) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            done  <= 1'b1;
            cnt   <= 4'd0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
